lite_reg_arbiter: RTL and testbench

//  Address decoder and arbiter for the xillybus_lite user register port (user_clk domain).

---
 rtl/lite_reg_arbiter_pkg.sv | 37 +++
 rtl/lite_reg_arbiter_irq_ctrl.sv | 74 +++++++
 rtl/lite_reg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_lite_reg_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lite_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lite_arb_pkg
// Brief   : Shared constants, read-source select and strobe helper for lite_reg_arbiter.
// Revision: 1.0
// ============================================================================
package lite_arb_pkg;

  localparam logic [31:0] OFF_ID       = 32'h0000_0000;
  localparam logic [31:0] OFF_IRQ_PEND = 32'h0000_0004;
  localparam logic [31:0] OFF_IRQ_EN   = 32'h0000_0008;
  localparam logic [31:0] OFF_IRQ_RAW  = 32'h0000_000C;
  localparam logic [31:0] OFF_BAD_ADDR = 32'h0000_0010;
  localparam logic [31:0] OFF_BAD_CNT  = 32'h0000_0014;
  localparam logic [31:0] OFF_SCRATCH  = 32'h0000_0018;

  localparam logic [31:0] BAD_DATA   = 32'hDEAD_BEEF;
  localparam int          ARM_CYCLES = 3;
  localparam int          BAD_CNT_W  = 16;

  typedef enum logic [1:0] {
    SEL_SLV   = 2'd0,
    SEL_LOCAL = 2'd1,
    SEL_BAD   = 2'd2
  } rd_sel_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lite_reg_arbiter_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lite_irq_ctrl
// Brief   : Source synchroniser, rising-edge latch, enable mask and W1C pending.
// Revision: 1.0
// ============================================================================
module lite_irq_ctrl
  import lite_arb_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] i_src,
  input  logic             i_en_we,
  input  logic             i_pend_we,
  input  logic [N_IRQ-1:0] i_wr_data,
  input  logic [N_IRQ-1:0] i_wr_mask,
  output logic [N_IRQ-1:0] o_pend,
  output logic [N_IRQ-1:0] o_en,
  output logic [N_IRQ-1:0] o_raw,
  output logic             o_irq
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_en;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_irq;

  logic             w_armed;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_clr;

  // Sources already high at reset release produce a sync-chain edge before arming completes.
  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));
  assign w_rise  = r_sync2 & ~r_prev & {N_IRQ{w_armed}};
  assign w_clr   = i_pend_we ? (i_wr_data & i_wr_mask) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_pend    <= '0;
      r_en      <= '0;
      r_arm_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (i_en_we) begin
        r_en <= (r_en & ~i_wr_mask) | (i_wr_data & i_wr_mask);
      end
      r_irq <= |(r_pend & r_en);
    end
  end

  assign o_pend = r_pend;
  assign o_en   = r_en;
  assign o_raw  = r_sync2;
  assign o_irq  = r_irq;

endmodule
`default_nettype wire

// File: rtl/lite_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lite_reg_arbiter
// Brief   : Register-port decoder routing accesses to slave windows or a local bank.
// Revision: 1.0
// ============================================================================
module lite_reg_arbiter
  import lite_arb_pkg::*;
#(
  parameter int          N_SLV    = 4,
  parameter int          WIN_BITS = 12,
  parameter int          N_IRQ    = 8,
  parameter logic [31:0] ID_VALUE = 32'h4C52_4131
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  user_wren,
  input  logic [3:0]            user_wstrb,
  input  logic                  user_rden,
  input  logic [31:0]           user_addr,
  input  logic [31:0]           user_wr_data,
  output logic [31:0]           user_rd_data,
  output logic                  user_irq,
  output logic [N_SLV-1:0]      slv_wren,
  output logic [N_SLV-1:0]      slv_rden,
  output logic [WIN_BITS-1:0]   slv_addr,
  output logic [31:0]           slv_wr_data,
  output logic [3:0]            slv_wstrb,
  input  logic [32*N_SLV-1:0]   slv_rd_data,
  input  logic [N_IRQ-1:0]      irq_src
);

  localparam int IDX_W = 16 - WIN_BITS;

  logic [IDX_W-1:0]     w_idx;
  logic                 w_hi_zero;
  logic [N_SLV-1:0]     w_slv_sel;
  logic                 w_slv_hit;
  logic                 w_loc_hit;
  logic                 w_bad_acc;
  logic                 w_loc_wr;
  logic [31:0]          w_off;
  logic [31:0]          w_mask;
  logic [31:0]          w_loc_rd;
  logic [31:0]          w_slv_mux;
  logic [N_IRQ-1:0]     w_pend;
  logic [N_IRQ-1:0]     w_en;
  logic [N_IRQ-1:0]     w_raw;

  rd_sel_e              r_sel;
  logic [N_SLV-1:0]     r_slv_oh;
  logic [31:0]          r_rd_data;
  logic [31:0]          r_scratch;
  logic [31:0]          r_bad_addr;
  logic [BAD_CNT_W-1:0] r_bad_cnt;

  assign w_idx     = user_addr[15:WIN_BITS];
  assign w_hi_zero = (user_addr[31:16] == 16'h0000);

  always_comb begin
    w_slv_sel = '0;
    for (int k = 0; k < N_SLV; k++) begin
      w_slv_sel[k] = w_hi_zero && (w_idx == IDX_W'(k));
    end
  end

  assign w_slv_hit = |w_slv_sel;
  assign w_loc_hit = w_hi_zero && (&w_idx);
  assign w_bad_acc = (user_wren || user_rden) && !w_slv_hit && !w_loc_hit;
  assign w_loc_wr  = user_wren && w_loc_hit;
  assign w_off     = 32'(user_addr[WIN_BITS-1:0]);
  assign w_mask    = strb_to_mask(user_wstrb);

  assign slv_wren    = w_slv_sel & {N_SLV{user_wren}};
  assign slv_rden    = w_slv_sel & {N_SLV{user_rden}};
  assign slv_addr    = user_addr[WIN_BITS-1:0];
  assign slv_wr_data = user_wr_data;
  assign slv_wstrb   = user_wstrb;

  always_comb begin
    w_loc_rd = '0;
    case (w_off)
      OFF_ID:       w_loc_rd = ID_VALUE;
      OFF_IRQ_PEND: w_loc_rd = 32'(w_pend);
      OFF_IRQ_EN:   w_loc_rd = 32'(w_en);
      OFF_IRQ_RAW:  w_loc_rd = 32'(w_raw);
      OFF_BAD_ADDR: w_loc_rd = r_bad_addr;
      OFF_BAD_CNT:  w_loc_rd = 32'(r_bad_cnt);
      OFF_SCRATCH:  w_loc_rd = r_scratch;
      default:      w_loc_rd = '0;
    endcase
  end

  // Local and unmapped reads are captured at T; slave data arrives live at T+1.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_sel     <= SEL_LOCAL;
      r_slv_oh  <= '0;
      r_rd_data <= '0;
    end else if (user_rden) begin
      r_slv_oh <= w_slv_sel;
      if (w_slv_hit) begin
        r_sel <= SEL_SLV;
      end else if (w_loc_hit) begin
        r_sel     <= SEL_LOCAL;
        r_rd_data <= w_loc_rd;
      end else begin
        r_sel     <= SEL_BAD;
        r_rd_data <= BAD_DATA;
      end
    end
  end

  always_comb begin
    w_slv_mux = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (r_slv_oh[k]) begin
        w_slv_mux = slv_rd_data[32*k +: 32];
      end
    end
  end

  assign user_rd_data = (r_sel == SEL_SLV) ? w_slv_mux : r_rd_data;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_scratch  <= '0;
      r_bad_addr <= '0;
      r_bad_cnt  <= '0;
    end else begin
      if (w_loc_wr && (w_off == OFF_SCRATCH)) begin
        r_scratch <= (r_scratch & ~w_mask) | (user_wr_data & w_mask);
      end
      if (w_bad_acc) begin
        r_bad_addr <= user_addr;
      end
      // A clearing write overrides a simultaneous unmapped increment.
      if (w_loc_wr && (w_off == OFF_BAD_CNT)) begin
        r_bad_cnt <= '0;
      end else if (w_bad_acc && (r_bad_cnt != '1)) begin
        r_bad_cnt <= r_bad_cnt + BAD_CNT_W'(1);
      end
    end
  end

  lite_irq_ctrl #(
    .N_IRQ (N_IRQ)
  ) u_irq_ctrl (
    .clk       (user_clk),
    .rst       (user_rst),
    .i_src     (irq_src),
    .i_en_we   (w_loc_wr && (w_off == OFF_IRQ_EN)),
    .i_pend_we (w_loc_wr && (w_off == OFF_IRQ_PEND)),
    .i_wr_data (user_wr_data[N_IRQ-1:0]),
    .i_wr_mask (w_mask[N_IRQ-1:0]),
    .o_pend    (w_pend),
    .o_en      (w_en),
    .o_raw     (w_raw),
    .o_irq     (user_irq)
  );

endmodule
`default_nettype wire

// File: tb/tb_lite_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lite_reg_arbiter
// Brief   : Scoreboard bench for lite_reg_arbiter with a simple memory slave per window.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lite_reg_arbiter;

  localparam int          N_SLV    = 4;
  localparam int          WIN_BITS = 12;
  localparam int          N_IRQ    = 8;
  localparam logic [31:0] ID_VAL   = 32'h4C52_4131;
  localparam logic [31:0] LOC      = 32'h0000_F000;
  localparam logic [31:0] BADV     = 32'hDEAD_BEEF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wren;
  logic [3:0]            wstrb;
  logic                  rden;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [31:0]           rd_data;
  logic                  irq;
  logic [N_SLV-1:0]      s_wren;
  logic [N_SLV-1:0]      s_rden;
  logic [WIN_BITS-1:0]   s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic [32*N_SLV-1:0]   s_rdata;
  logic [N_IRQ-1:0]      irq_src;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic        rd_pend = 1'b0;
  logic [31:0] slv_mem [N_SLV];

  lite_reg_arbiter #(
    .N_SLV(N_SLV), .WIN_BITS(WIN_BITS), .N_IRQ(N_IRQ), .ID_VALUE(ID_VAL)
  ) dut (
    .user_clk(clk), .user_rst(rst), .user_wren(wren), .user_wstrb(wstrb),
    .user_rden(rden), .user_addr(addr), .user_wr_data(wdata),
    .user_rd_data(rd_data), .user_irq(irq),
    .slv_wren(s_wren), .slv_rden(s_rden), .slv_addr(s_addr),
    .slv_wr_data(s_wdata), .slv_wstrb(s_wstrb), .slv_rd_data(s_rdata),
    .irq_src(irq_src)
  );

  always #5 clk = ~clk;

  // One-word memory per window; read data valid the cycle after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < N_SLV; k++) begin
      if (s_wren[k]) slv_mem[k] <= s_wdata;
      if (s_rden[k]) s_rdata[32*k +: 32] <= slv_mem[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) rd_pend <= rden && !rst;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb.size() == 0) check("sb_pop_empty", 32'(sb.size()), 32'd1);
      else                check("rd_data", rd_data, sb.pop_front());
    end
  end

  task automatic acc(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] st,
                     input logic [31:0] exp_rd, input logic [N_SLV-1:0] oh);
    @(negedge clk);
    wren = we; rden = re; addr = a; wdata = d; wstrb = st;
    if (re) sb.push_back(exp_rd);
    #1;
    check("slv_wren", 32'(s_wren), we ? 32'(oh) : 32'd0);
    check("slv_rden", 32'(s_rden), re ? 32'(oh) : 32'd0);
    @(posedge clk);
    #1;
    wren = 1'b0; rden = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                    input logic [N_SLV-1:0] oh);
    acc(1'b1, 1'b0, a, d, st, 32'd0, oh);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [N_SLV-1:0] oh);
    acc(1'b0, 1'b1, a, 32'd0, 4'h0, exp, oh);
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    s_rdata = '0; irq_src = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(posedge clk);
    rd(LOC + 32'h04, 32'h0, 4'b0000);
    rd(LOC + 32'h0C, 32'hFF, 4'b0000);

    // Slave window routing
    @(negedge clk);
    wren = 1'b1; addr = 32'h0000_1008; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    #1;
    check("t1_wren", 32'(s_wren), 32'b0010);
    check("t1_addr", 32'(s_addr), 32'h008);
    check("t1_wdata", s_wdata, 32'hA5A5_A5A5);
    @(posedge clk);
    #1 wren = 1'b0;
    rd(32'h0000_1008, 32'hA5A5_A5A5, 4'b0010);
    wr(32'h0000_3010, 32'h3C3C_0003, 4'hF, 4'b1000);
    wr(32'h0000_1008, 32'h1234_5678, 4'hF, 4'b0010);
    rd(32'h0000_1008, 32'h1234_5678, 4'b0010);
    rd(32'h0000_3000, 32'h3C3C_0003, 4'b1000);

    // Local bank
    rd(LOC, ID_VAL, 4'b0000);
    wr(LOC + 32'h18, 32'hFFFF_FFFF, 4'hF, 4'b0000);
    wr(LOC + 32'h18, 32'h0, 4'b0010, 4'b0000);
    rd(LOC + 32'h18, 32'hFFFF_00FF, 4'b0000);
    acc(1'b1, 1'b1, LOC + 32'h18, 32'h1122_3344, 4'hF, 32'hFFFF_00FF, 4'b0000);
    rd(LOC + 32'h18, 32'h1122_3344, 4'b0000);
    rd(LOC + 32'h1C, 32'h0, 4'b0000);

    // Unmapped accesses
    rd(32'h0000_5000, BADV, 4'b0000);
    wr(32'h0002_0000, 32'h5555_5555, 4'hF, 4'b0000);
    rd(LOC + 32'h14, 32'd2, 4'b0000);
    rd(LOC + 32'h10, 32'h0002_0000, 4'b0000);
    wr(LOC + 32'h14, 32'h0, 4'h0, 4'b0000);
    rd(LOC + 32'h14, 32'd0, 4'b0000);

    // Interrupts
    wr(LOC + 32'h08, 32'hFFFF_FFFF, 4'hF, 4'b0000);
    rd(LOC + 32'h08, 32'h0000_00FF, 4'b0000);
    wr(LOC + 32'h08, 32'h0000_0001, 4'hF, 4'b0000);
    @(negedge clk) irq_src = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk) irq_src = 8'h01;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    irq_src = 8'h00;
    rd(LOC + 32'h04, 32'h1, 4'b0000);
    wr(LOC + 32'h04, 32'h1, 4'h1, 4'b0000);
    check("irq_lag", 32'(irq), 32'd1);
    @(posedge clk);
    #1 check("irq_clr", 32'(irq), 32'd0);
    rd(LOC + 32'h04, 32'h0, 4'b0000);
    @(negedge clk) irq_src = 8'h01;
    @(posedge clk);
    @(posedge clk);
    wr(LOC + 32'h04, 32'h1, 4'h1, 4'b0000);
    rd(LOC + 32'h04, 32'h1, 4'b0000);

    // Reset in the cycle after a read
    irq_src = 8'h00;
    rd(LOC + 32'h18, 32'h1122_3344, 4'b0000);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_rd", rd_data, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_mid_irq", 32'(irq), 32'd0);
    for (int o = 4; o <= 24; o += 4) begin
      rd(LOC + 32'(o), 32'h0, 4'b0000);
    end

    // Saturating bad-access counter
    @(negedge clk);
    rden = 1'b1; addr = 32'h0000_7000;
    for (int i = 0; i < 65536; i++) begin
      sb.push_back(BADV);
      @(posedge clk);
    end
    #1 rden = 1'b0;
    rd(LOC + 32'h14, 32'h0000_FFFF, 4'b0000);
    rd(LOC + 32'h10, 32'h0000_7000, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
